elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Car-motion scheduler for the 7-floor elevator using collective (SCAN) control.
- Consumes the per-floor hall-call vectors from the up/down passenger decoder plus the in-car destination vector.
- Sequences the car through move, stop and door phases, and tracks current floor and travel direction.
- Emits a one-cycle arrival strobe that the boarding/remaining-passenger logic uses to update its floor registers.

Parameters:
FLOOR_TICKS, 4, clock cycles to travel one floor (>=2)
DOOR_TICKS, 3, clock cycles the door stays open per stop (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
up_req  in  7  bit i = floor i+1 has a passenger going up (bit 6 always 0)
down_req  in  7  bit i = floor i+1 has a passenger going down (bit 0 always 0)
car_dest  in  7  bit i = an onboard passenger exits at floor i+1
door_hold  in  1  extends the door-open phase while high
floor  out  3  current floor, 1..7
dir  out  2  00 none, 01 up, 10 down
moving  out  1  high in MOVE state
door_open  out  1  high in DOOR state
arrive  out  1  one-cycle pulse on DOOR entry; floor is valid that cycle

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, floor=1, dir=00, moving=0, door_open=0, arrive=0, timer=0. Reset mid-move or mid-door aborts immediately and returns the car to floor 1.
- Definitions, evaluated on the floor value F used in each decision:
  - req_any = up_req | down_req | car_dest.
  - above(F) = any req_any bit at floors > F.
  - below(F) = any req_any bit at floors < F.
  - here(F) = req_any bit for floor F.
- States: IDLE, MOVE, DOOR. All outputs are registered.
- IDLE, priority order:
  1. here(floor) -> DOOR. dir=01 if up_req[floor], else 10 if down_req[floor], else 00.
  2. Else above -> MOVE, dir=01.
  3. Else below -> MOVE, dir=10 (up wins on tie).
  4. Else stay in IDLE, dir=00.
- MOVE timing:
  - On entry the timer loads FLOOR_TICKS-1 and decrements each cycle.
  - When the timer is 0, floor advances by +1 (dir=01) or -1 (dir=10) on that edge, so the car spends exactly FLOOR_TICKS cycles per floor.
- MOVE stop decision, made on the same edge using the next floor N and the inputs sampled that cycle. Stop (-> DOOR next) if any of:
  - car_dest[N];
  - dir=01 and up_req[N];
  - dir=10 and down_req[N];
  - dir=01 and !above(N);
  - dir=10 and !below(N);
  - N==7 or N==1 (hard limits; floor never leaves 1..7).
  Otherwise reload the timer and continue MOVE.
- DOOR timing:
  - arrive pulses in the first DOOR cycle.
  - The timer loads DOOR_TICKS-1, so door_open is high DOOR_TICKS cycles.
  - If door_hold is high in any DOOR cycle, the timer reloads DOOR_TICKS-1.
- DOOR exit, when the timer is 0 and door_hold is low:
  - dir=01 and above -> MOVE up.
  - dir=10 and below -> MOVE down.
  - Otherwise -> IDLE with dir=00. IDLE then re-evaluates, which handles reversal and same-floor opposite-direction calls.
- Requests that appear or drop mid-travel take effect at the next floor-boundary decision. A request that drops before its floor boundary does not cause a stop.
- moving and door_open are never high together.

Test Plan:
Use FLOOR_TICKS=4 and DOOR_TICKS=3 unless noted.
1. Reset: assert rst_n=0 mid-MOVE at floor 3 -> same cycle floor=1, dir=00, moving=0, door_open=0; after release with no requests, the block stays in IDLE.
2. Same-floor call: at floor 1 in IDLE, set up_req[0]=1 -> next cycle door_open=1, arrive=1 for one cycle, dir=01; door_open stays high 3 cycles, then IDLE with dir=00 once up_req is cleared.
3. End-of-run stop: from floor 1, set down_req[4]=1 (floor 5) -> moving=1, floor steps 2,3,4,5 every 4 cycles; DOOR at floor 5 after 16 cycles of MOVE; dir=10 is set on the following IDLE re-evaluation.
4. Collective skip and reverse: from floor 1 with car_dest[6]=1 and down_req[3]=1 -> passes floor 4 without stopping and stops at 7; after the door closes with car_dest cleared, moves down and stops at floor 4, arrive=1 there.
5. Door hold: in DOOR, hold door_hold=1 for 5 cycles -> door_open stays high through the hold plus 3 more cycles; no MOVE starts before then.
6. Boundary: at floor 7 in DOOR with only car_dest[0]=1 -> door closes, IDLE, MOVE with dir=10; 24 cycles later floor=1 and arrive pulses; floor never goes outside 1..7.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Collective (SCAN) car scheduler for a 7-floor elevator: sequences IDLE/MOVE/DOOR,
// tracks floor and direction, and pulses arrive on every door opening.
module elevator_ctrl #(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] up_req,
  input  logic [6:0] down_req,
  input  logic [6:0] car_dest,
  input  logic       door_hold,
  output logic [2:0] floor,
  output logic [1:0] dir,
  output logic       moving,
  output logic       door_open,
  output logic       arrive
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] FT_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DT_LOAD = TW'(DOOR_TICKS - 1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t        state_q,  state_d;
  logic [2:0]    floor_q,  floor_d;
  logic [1:0]    dir_q,    dir_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic          arrive_q, arrive_d;

  logic [6:0] req_any;
  logic [2:0] next_floor;
  logic       stop_next;

  // Floor f (1..7) maps to vector bit f-1.
  function automatic logic any_above(input logic [6:0] v, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i >= int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [6:0] v, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i + 1 < int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  function automatic logic bit_at(input logic [6:0] v, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i + 1 == int'(f)) r = v[i];
    end
    return r;
  endfunction

  assign req_any = up_req | down_req | car_dest;

  // Saturate at the shaft ends so floor can never leave 1..7.
  always_comb begin
    next_floor = floor_q;
    if (dir_q == DIR_UP && floor_q != 3'd7) begin
      next_floor = floor_q + 3'd1;
    end else if (dir_q == DIR_DN && floor_q != 3'd1) begin
      next_floor = floor_q - 3'd1;
    end
  end

  always_comb begin
    stop_next = 1'b0;
    if (bit_at(car_dest, next_floor))                          stop_next = 1'b1;
    if (dir_q == DIR_UP && bit_at(up_req, next_floor))         stop_next = 1'b1;
    if (dir_q == DIR_DN && bit_at(down_req, next_floor))       stop_next = 1'b1;
    if (dir_q == DIR_UP && !any_above(req_any, next_floor))    stop_next = 1'b1;
    if (dir_q == DIR_DN && !any_below(req_any, next_floor))    stop_next = 1'b1;
    if (dir_q == DIR_NONE)                                     stop_next = 1'b1;
    if (next_floor == 3'd7 || next_floor == 3'd1)              stop_next = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    arrive_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bit_at(req_any, floor_q)) begin
          state_d  = S_DOOR;
          timer_d  = DT_LOAD;
          arrive_d = 1'b1;
          if (bit_at(up_req, floor_q)) begin
            dir_d = DIR_UP;
          end else if (bit_at(down_req, floor_q)) begin
            dir_d = DIR_DN;
          end else begin
            dir_d = DIR_NONE;
          end
        end else if (any_above(req_any, floor_q)) begin
          state_d = S_MOVE;
          dir_d   = DIR_UP;
          timer_d = FT_LOAD;
        end else if (any_below(req_any, floor_q)) begin
          state_d = S_MOVE;
          dir_d   = DIR_DN;
          timer_d = FT_LOAD;
        end else begin
          dir_d = DIR_NONE;
        end
      end

      S_MOVE: begin
        if (timer_q == '0) begin
          floor_d = next_floor;
          if (stop_next) begin
            state_d  = S_DOOR;
            timer_d  = DT_LOAD;
            arrive_d = 1'b1;
          end else begin
            timer_d = FT_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_DOOR: begin
        if (door_hold) begin
          timer_d = DT_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (dir_q == DIR_UP && any_above(req_any, floor_q)) begin
          state_d = S_MOVE;
          timer_d = FT_LOAD;
        end else if (dir_q == DIR_DN && any_below(req_any, floor_q)) begin
          state_d = S_MOVE;
          timer_d = FT_LOAD;
        end else begin
          // IDLE re-evaluates next cycle, which covers reversal and same-floor calls.
          state_d = S_IDLE;
          dir_d   = DIR_NONE;
          timer_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_NONE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      floor_q  <= 3'd1;
      dir_q    <= DIR_NONE;
      timer_q  <= '0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      arrive_q <= arrive_d;
    end
  end

  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);
  assign arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed self-checking bench for elevator_ctrl (FLOOR_TICKS=4, DOOR_TICKS=3).
module tb_elevator_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] up_req;
  logic [6:0] down_req;
  logic [6:0] car_dest;
  logic       door_hold;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       moving;
  logic       door_open;
  logic       arrive;

  int total = 0;
  int bad   = 0;

  elevator_ctrl #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_req    (up_req),
    .down_req  (down_req),
    .car_dest  (car_dest),
    .door_hold (door_hold),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_req = '0; down_req = '0; car_dest = '0; door_hold = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (floor !== 3'd1 || dir !== 2'b00 || moving !== 1'b0 || door_open !== 1'b0 || arrive !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: floor=%0d dir=%b mv=%b door=%b arr=%b want 1 00 0 0 0", floor, dir, moving, door_open, arrive);
    end
    car_dest = 7'b0010000;
    tick(1);
    total++;
    if (moving !== 1'b1 || dir !== 2'b01 || floor !== 3'd1) begin
      bad++;
      $display("FAIL reset_move_start: mv=%b dir=%b floor=%0d want 1 01 1", moving, dir, floor);
    end
    tick(9);
    total++;
    if (floor !== 3'd3 || moving !== 1'b1) begin
      bad++;
      $display("FAIL reset_at_floor3: floor=%0d mv=%b want 3 1", floor, moving);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (floor !== 3'd1 || dir !== 2'b00 || moving !== 1'b0 || door_open !== 1'b0 || arrive !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_abort: floor=%0d dir=%b mv=%b door=%b arr=%b want 1 00 0 0 0", floor, dir, moving, door_open, arrive);
    end
    car_dest = '0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    total++;
    if (floor !== 3'd1 || dir !== 2'b00 || moving !== 1'b0 || door_open !== 1'b0) begin
      bad++;
      $display("FAIL reset_stays_idle: floor=%0d dir=%b mv=%b door=%b want 1 00 0 0", floor, dir, moving, door_open);
    end
  endtask

  task automatic test_same_floor();
    up_req = 7'b0000001;
    tick(1);
    total++;
    if (door_open !== 1'b1 || arrive !== 1'b1 || dir !== 2'b01 || moving !== 1'b0) begin
      bad++;
      $display("FAIL same_floor_open: door=%b arr=%b dir=%b mv=%b want 1 1 01 0", door_open, arrive, dir, moving);
    end
    up_req = '0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      total++;
      if (door_open !== 1'b1 || arrive !== 1'b0) begin
        bad++;
        $display("FAIL same_floor_hold%0d: door=%b arr=%b want 1 0", i, door_open, arrive);
      end
    end
    tick(1);
    total++;
    if (door_open !== 1'b0 || dir !== 2'b00 || moving !== 1'b0) begin
      bad++;
      $display("FAIL same_floor_close: door=%b dir=%b mv=%b want 0 00 0", door_open, dir, moving);
    end
    tick(1);
    total++;
    if (door_open !== 1'b0 || moving !== 1'b0 || floor !== 3'd1) begin
      bad++;
      $display("FAIL same_floor_idle: door=%b mv=%b floor=%0d want 0 0 1", door_open, moving, floor);
    end
  endtask

  task automatic test_end_of_run();
    down_req = 7'b0010000;
    tick(1);
    total++;
    if (moving !== 1'b1 || dir !== 2'b01 || floor !== 3'd1) begin
      bad++;
      $display("FAIL eor_start: mv=%b dir=%b floor=%0d want 1 01 1", moving, dir, floor);
    end
    for (int f = 2; f <= 4; f++) begin
      tick(4);
      total++;
      if (floor !== 3'(f) || moving !== 1'b1 || door_open !== 1'b0) begin
        bad++;
        $display("FAIL eor_step: floor=%0d mv=%b door=%b want %0d 1 0", floor, moving, door_open, f);
      end
    end
    tick(3);
    total++;
    if (floor !== 3'd4 || moving !== 1'b1) begin
      bad++;
      $display("FAIL eor_last_move: floor=%0d mv=%b want 4 1", floor, moving);
    end
    tick(1);
    total++;
    if (floor !== 3'd5 || door_open !== 1'b1 || arrive !== 1'b1 || moving !== 1'b0 || dir !== 2'b01) begin
      bad++;
      $display("FAIL eor_stop5: floor=%0d door=%b arr=%b mv=%b dir=%b want 5 1 1 0 01", floor, door_open, arrive, moving, dir);
    end
    tick(3);
    total++;
    if (door_open !== 1'b0 || dir !== 2'b00) begin
      bad++;
      $display("FAIL eor_idle: door=%b dir=%b want 0 00", door_open, dir);
    end
    tick(1);
    total++;
    if (door_open !== 1'b1 || arrive !== 1'b1 || dir !== 2'b10 || floor !== 3'd5) begin
      bad++;
      $display("FAIL eor_reopen_down: door=%b arr=%b dir=%b floor=%0d want 1 1 10 5", door_open, arrive, dir, floor);
    end
    down_req = '0;
    tick(3);
    total++;
    if (door_open !== 1'b0 || dir !== 2'b00 || floor !== 3'd5 || moving !== 1'b0) begin
      bad++;
      $display("FAIL eor_done: door=%b dir=%b floor=%0d mv=%b want 0 00 5 0", door_open, dir, floor, moving);
    end
  endtask

  task automatic test_collective();
    do_reset();
    car_dest = 7'b1000000;
    down_req = 7'b0001000;
    tick(13);
    total++;
    if (floor !== 3'd4 || moving !== 1'b1 || door_open !== 1'b0 || arrive !== 1'b0) begin
      bad++;
      $display("FAIL coll_skip4: floor=%0d mv=%b door=%b arr=%b want 4 1 0 0", floor, moving, door_open, arrive);
    end
    tick(12);
    total++;
    if (floor !== 3'd7 || door_open !== 1'b1 || arrive !== 1'b1) begin
      bad++;
      $display("FAIL coll_stop7: floor=%0d door=%b arr=%b want 7 1 1", floor, door_open, arrive);
    end
    car_dest = '0;
    tick(4);
    total++;
    if (moving !== 1'b1 || dir !== 2'b10 || floor !== 3'd7) begin
      bad++;
      $display("FAIL coll_reverse: mv=%b dir=%b floor=%0d want 1 10 7", moving, dir, floor);
    end
    tick(11);
    total++;
    if (floor !== 3'd5 || moving !== 1'b1) begin
      bad++;
      $display("FAIL coll_pass5: floor=%0d mv=%b want 5 1", floor, moving);
    end
    tick(1);
    total++;
    if (floor !== 3'd4 || door_open !== 1'b1 || arrive !== 1'b1 || moving !== 1'b0) begin
      bad++;
      $display("FAIL coll_stop4: floor=%0d door=%b arr=%b mv=%b want 4 1 1 0", floor, door_open, arrive, moving);
    end
    down_req = '0;
    tick(3);
    total++;
    if (door_open !== 1'b0 || moving !== 1'b0 || dir !== 2'b00) begin
      bad++;
      $display("FAIL coll_idle: door=%b mv=%b dir=%b want 0 0 00", door_open, moving, dir);
    end
  endtask

  task automatic test_door_hold();
    up_req = 7'b0001000;
    tick(1);
    total++;
    if (door_open !== 1'b1 || arrive !== 1'b1 || dir !== 2'b01 || floor !== 3'd4) begin
      bad++;
      $display("FAIL hold_open: door=%b arr=%b dir=%b floor=%0d want 1 1 01 4", door_open, arrive, dir, floor);
    end
    up_req = '0;
    car_dest = 7'b0100000;
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      total++;
      if (door_open !== 1'b1 || moving !== 1'b0) begin
        bad++;
        $display("FAIL hold_during%0d: door=%b mv=%b want 1 0", i, door_open, moving);
      end
    end
    door_hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      total++;
      if (door_open !== 1'b1 || moving !== 1'b0) begin
        bad++;
        $display("FAIL hold_tail%0d: door=%b mv=%b want 1 0", i, door_open, moving);
      end
    end
    tick(1);
    total++;
    if (door_open !== 1'b0 || moving !== 1'b1 || dir !== 2'b01) begin
      bad++;
      $display("FAIL hold_release: door=%b mv=%b dir=%b want 0 1 01", door_open, moving, dir);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    car_dest = 7'b1000000;
    tick(25);
    total++;
    if (floor !== 3'd7 || door_open !== 1'b1 || arrive !== 1'b1) begin
      bad++;
      $display("FAIL bnd_top: floor=%0d door=%b arr=%b want 7 1 1", floor, door_open, arrive);
    end
    car_dest = 7'b0000001;
    tick(3);
    total++;
    if (door_open !== 1'b0 || moving !== 1'b0 || dir !== 2'b00 || floor !== 3'd7) begin
      bad++;
      $display("FAIL bnd_idle: door=%b mv=%b dir=%b floor=%0d want 0 0 00 7", door_open, moving, dir, floor);
    end
    tick(1);
    total++;
    if (moving !== 1'b1 || dir !== 2'b10 || floor !== 3'd7) begin
      bad++;
      $display("FAIL bnd_down_start: mv=%b dir=%b floor=%0d want 1 10 7", moving, dir, floor);
    end
    for (int i = 0; i < 23; i++) begin
      tick(1);
      total++;
      if (floor < 3'd1 || floor > 3'd7 || moving !== 1'b1 || door_open !== 1'b0) begin
        bad++;
        $display("FAIL bnd_travel%0d: floor=%0d mv=%b door=%b want 1..7 1 0", i, floor, moving, door_open);
      end
    end
    total++;
    if (floor !== 3'd2 || arrive !== 1'b0) begin
      bad++;
      $display("FAIL bnd_floor2: floor=%0d arr=%b want 2 0", floor, arrive);
    end
    tick(1);
    total++;
    if (floor !== 3'd1 || arrive !== 1'b1 || door_open !== 1'b1 || moving !== 1'b0) begin
      bad++;
      $display("FAIL bnd_bottom: floor=%0d arr=%b door=%b mv=%b want 1 1 1 0", floor, arrive, door_open, moving);
    end
    car_dest = '0;
    tick(3);
    total++;
    if (floor !== 3'd1 || door_open !== 1'b0 || moving !== 1'b0 || dir !== 2'b00) begin
      bad++;
      $display("FAIL bnd_done: floor=%0d door=%b mv=%b dir=%b want 1 0 0 00", floor, door_open, moving, dir);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    up_req = '0; down_req = '0; car_dest = '0; door_hold = 1'b0;
    test_reset();
    test_same_floor();
    test_end_of_run();
    test_collective();
    test_door_hold();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
